sevenseg_rx: RTL and testbench
==============================

SEVENSEG_RX -- requirements
Module: sevenseg_rx

Interface
REQ-001 Parameter SETTLE, default 4, range 1..255: the number of consecutive identical synchronized samples required before a digit is captured.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 segs_n  input  7  segment lines, active-low; bit0=a, bit1=b, ..., bit6=g.
REQ-005 dp_n  input  1  decimal point line, active-low.
REQ-006 an_n  input  8  digit anodes, active-low; bit i selects digit i.
REQ-007 d7..d0  output  7 each  recovered digit codes {blank, dp, dash, hex[3:0]}, registered.
REQ-008 valid  output  8  sticky per-digit flag; bit i=1 once d_i has been captured since reset.
REQ-009 frame_done  output  1  one-cycle pulse when all 8 digits have been captured in the current frame.
REQ-010 err  output  1  one-cycle pulse when a settled pattern cannot be decoded.

Function
REQ-011 segs_n, dp_n and an_n shall each pass through a 2-flop synchronizer; all further logic uses the synchronized copies.
REQ-012 The block shall hold a stability counter of 8 bits that clears to 0 whenever any synchronized input bit differs from its previous-cycle value, and otherwise increments, saturating at 255.
REQ-013 A capture event shall occur on the cycle the counter reaches SETTLE-1, if synchronized an_n has exactly one bit low. A capture event occurs at most once per stable interval.
REQ-014 If an_n is all-high or has more than one bit low, no capture or err shall occur.
REQ-015 Decode uses s = ~segs_n and p = ~dp_n.
REQ-016 s values 0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 shall decode to hex 0..F, with code {0,p,0,hex}.
REQ-017 s=0x40 shall decode to the dash code {0,p,1,0000}.
REQ-018 s=0x00 with p=0 shall decode to the blank code 7'b100_0000.
REQ-019 Any other combination, including s=0x00 with p=1, is undecodable. On a capture event it shall pulse err for 1 cycle, leave d_i and valid unchanged, and not mark the digit seen.
REQ-020 On a decodable capture for digit i, the following shall take effect on the next clock edge: d_i <= code, valid[i] <= 1, seen[i] <= 1.
REQ-021 Input-to-d_i latency from the last input change shall be 2 (sync) + SETTLE cycles.
REQ-022 When a capture makes seen == 8'hFF, frame_done shall pulse high for exactly 1 cycle, coincident with the d_i update. seen shall clear to 0 on the same edge.
REQ-023 Re-capturing an already-seen digit before the frame completes shall update d_i only; frame_done is not asserted.
REQ-024 frame_done and err shall never assert in the same cycle.

Reset
REQ-025 On rst_n=0, asynchronously:
- d7..d0 = 7'b100_0000 (blank)
- valid = 0, seen = 0
- frame_done = 0, err = 0
- stability counter = 0
- synchronizer flops = all ones (inactive)
REQ-026 Reset asserted mid-dwell shall discard any partial stability count; no capture occurs until SETTLE fresh stable cycles follow reset release.

Verification
REQ-027 SETTLE=4; an_n=8'hFE, segs_n=~7'h06, dp_n=0 held for 10 cycles -> d0=7'b010_0001 at cycle 6, valid=8'h01, no err.
REQ-028 All 8 digits driven in turn with hex 0..7, 1 ms dwell each -> frame_done single pulse after digit 7 capture, seen cleared. Cycling continues -> frame_done once per frame.
REQ-029 segs_n=~7'h40 with dp_n=1 on anode 3 -> d3=7'b001_0000. segs_n=7'h7F, dp_n=1 on anode 5 -> d5=7'b100_0000.
REQ-030 segs_n=~7'h12 (undecodable) on anode 2 -> err pulse of 1 cycle, d2 and valid[2] unchanged. an_n=8'hFC (two anodes low) -> no err, no capture.
REQ-031 Input glitch (one-cycle segment change) every 3 cycles with SETTLE=4 -> no capture ever. Remove glitch -> capture after 4 stable cycles.
REQ-032 rst_n pulsed low at cycle 2 of a dwell -> all outputs at reset values immediately. After release, capture occurs SETTLE cycles after the synchronized inputs are stable.

Source files
------------

// File: rtl/sevenseg_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_rx_if
// Brief    : Bundle of seven-segment display lines and recovered digit outputs.
// Revision : 1.0
// ============================================================================
interface sevenseg_rx_if;
    logic [6:0]      segs_n;
    logic            dp_n;
    logic [7:0]      an_n;
    logic [7:0][6:0] d;
    logic [7:0]      valid;
    logic            frame_done;
    logic            err;

    modport master (
        output segs_n, dp_n, an_n,
        input  d, valid, frame_done, err
    );

    modport slave (
        input  segs_n, dp_n, an_n,
        output d, valid, frame_done, err
    );
endinterface
`default_nettype wire

// File: rtl/sevenseg_rx.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_rx
// Brief    : Recovers digit codes from a multiplexed 7-segment display bus.
// Revision : 1.0
// ============================================================================
module sevenseg_rx #(
    parameter int unsigned SETTLE = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    sevenseg_rx_if.slave bus
);

    localparam logic [7:0] c_SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [6:0] c_BLANK     = 7'b100_0000;

    logic [6:0]      r_segs_s1, r_segs_s2;
    logic            r_dp_s1,   r_dp_s2;
    logic [7:0]      r_an_s1,   r_an_s2;
    logic [7:0]      r_cnt;
    logic [7:0][6:0] r_d;
    logic [7:0]      r_valid;
    logic [7:0]      r_seen;
    logic            r_frame_done;
    logic            r_err;

    logic            w_change;
    logic [7:0]      w_an;
    logic            w_one_hot;
    logic            w_capture;
    logic [2:0]      w_idx;
    logic [7:0]      w_seen_next;
    logic [6:0]      w_s;
    logic            w_p;
    logic [3:0]      w_hex;
    logic            w_is_hex;
    logic [6:0]      w_code;
    logic            w_ok;

    // Stage-1 disagreeing with stage-2 means the synchronized copy changes on this edge.
    assign w_change  = {r_segs_s1, r_dp_s1, r_an_s1} != {r_segs_s2, r_dp_s2, r_an_s2};
    assign w_an      = ~r_an_s2;
    assign w_one_hot = (w_an != 8'h00) && ((w_an & (w_an - 8'd1)) == 8'h00);
    assign w_capture = (r_cnt == c_SETTLE_M1) && w_one_hot;
    assign w_seen_next = r_seen | w_an;

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_an[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_s      = ~r_segs_s2;
        w_p      = ~r_dp_s2;
        w_hex    = 4'h0;
        w_is_hex = 1'b1;
        case (w_s)
            7'h3F:   w_hex = 4'h0;
            7'h06:   w_hex = 4'h1;
            7'h5B:   w_hex = 4'h2;
            7'h4F:   w_hex = 4'h3;
            7'h66:   w_hex = 4'h4;
            7'h6D:   w_hex = 4'h5;
            7'h7D:   w_hex = 4'h6;
            7'h07:   w_hex = 4'h7;
            7'h7F:   w_hex = 4'h8;
            7'h6F:   w_hex = 4'h9;
            7'h77:   w_hex = 4'hA;
            7'h7C:   w_hex = 4'hB;
            7'h39:   w_hex = 4'hC;
            7'h5E:   w_hex = 4'hD;
            7'h79:   w_hex = 4'hE;
            7'h71:   w_hex = 4'hF;
            default: w_is_hex = 1'b0;
        endcase
    end

    always_comb begin
        w_code = c_BLANK;
        w_ok   = 1'b1;
        if (w_is_hex) begin
            w_code = {1'b0, w_p, 1'b0, w_hex};
        end else if (w_s == 7'h40) begin
            w_code = {1'b0, w_p, 1'b1, 4'h0};
        end else if ((w_s == 7'h00) && !w_p) begin
            w_code = c_BLANK;
        end else begin
            w_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segs_s1    <= '1;
            r_segs_s2    <= '1;
            r_dp_s1      <= 1'b1;
            r_dp_s2      <= 1'b1;
            r_an_s1      <= '1;
            r_an_s2      <= '1;
            r_cnt        <= 8'd0;
            r_d          <= {8{c_BLANK}};
            r_valid      <= 8'h00;
            r_seen       <= 8'h00;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_segs_s1 <= bus.segs_n;
            r_segs_s2 <= r_segs_s1;
            r_dp_s1   <= bus.dp_n;
            r_dp_s2   <= r_dp_s1;
            r_an_s1   <= bus.an_n;
            r_an_s2   <= r_an_s1;

            if (w_change) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end

            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            if (w_capture) begin
                if (w_ok) begin
                    r_d[w_idx]     <= w_code;
                    r_valid[w_idx] <= 1'b1;
                    if (w_seen_next == 8'hFF) begin
                        r_frame_done <= 1'b1;
                        r_seen       <= 8'h00;
                    end else begin
                        r_seen <= w_seen_next;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.d          = r_d;
    assign bus.valid      = r_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_rx
// Brief    : Directed and random dwell sequences checked against a digit model.
// Revision : 1.0
// ============================================================================
module tb_sevenseg_rx;

    localparam int unsigned SETTLE = 4;
    localparam int          LAT    = SETTLE + 2;

    logic clk;
    logic rst_n;
    sevenseg_rx_if u_if ();

    sevenseg_rx #(.SETTLE(SETTLE)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_errors = 0;
    int n_checks = 0;
    int n_both   = 0;

    always @(negedge clk) begin
        if (u_if.frame_done && u_if.err) n_both++;
    end

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: what each digit should show and which digits the frame has seen.
    logic [7:0][6:0] m_d;
    logic [7:0]      m_valid;
    logic [7:0]      m_seen;
    logic [15:0]     last_in;
    bit              pending;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_decode(input logic [6:0] segs_n, input logic dp_n,
                                      output logic [6:0] code);
        logic [6:0] s;
        logic       p;
        s    = ~segs_n;
        p    = ~dp_n;
        code = 7'b100_0000;
        for (int h = 0; h < 16; h++) begin
            if (font[h] == s) begin
                code = {1'b0, p, 1'b0, 4'(h)};
                return 1'b1;
            end
        end
        if (s == 7'h40) begin
            code = {1'b0, p, 1'b1, 4'h0};
            return 1'b1;
        end
        if (s == 7'h00 && !p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_d     = {8{7'b100_0000}};
        m_valid = 8'h00;
        m_seen  = 8'h00;
        last_in = 16'hFFFF;
        pending = ({u_if.an_n, u_if.segs_n, u_if.dp_n} != 16'hFFFF);
    endtask

    task automatic apply(input logic [7:0] an_n, input logic [6:0] segs_n, input logic dp_n);
        u_if.an_n   = an_n;
        u_if.segs_n = segs_n;
        u_if.dp_n   = dp_n;
        pending     = ({an_n, segs_n, dp_n} != last_in);
        last_in     = {an_n, segs_n, dp_n};
    endtask

    // Hold the applied inputs for 'cycles' edges; a fresh stable pattern lands LAT edges in.
    task automatic run(input int cycles);
        logic [7:0][6:0] old_d;
        logic [7:0]      old_valid;
        logic [6:0]      code;
        bit              exp_err, exp_fd;
        int              idx;
        old_d     = m_d;
        old_valid = m_valid;
        exp_err   = 1'b0;
        exp_fd    = 1'b0;
        if (pending && $countones(~u_if.an_n) == 1) begin
            idx = 0;
            for (int i = 0; i < 8; i++) if (!u_if.an_n[i]) idx = i;
            if (!ref_decode(u_if.segs_n, u_if.dp_n, code)) begin
                exp_err = 1'b1;
            end else begin
                m_d[idx]     = code;
                m_valid[idx] = 1'b1;
                m_seen[idx]  = 1'b1;
                if (m_seen == 8'hFF) begin
                    exp_fd = 1'b1;
                    m_seen = 8'h00;
                end
            end
        end
        pending = 1'b0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk);
            #1;
            chk("d",          64'(u_if.d),          64'((k >= LAT) ? m_d : old_d));
            chk("valid",      64'(u_if.valid),      64'((k >= LAT) ? m_valid : old_valid));
            chk("err",        64'(u_if.err),        64'(exp_err && k == LAT));
            chk("frame_done", 64'(u_if.frame_done), 64'(exp_fd && k == LAT));
        end
    endtask

    task automatic run_quiet(input int cycles);
        pending = 1'b0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk);
            #1;
            chk("quiet_d",     64'(u_if.d),          64'(m_d));
            chk("quiet_valid", 64'(u_if.valid),      64'(m_valid));
            chk("quiet_err",   64'(u_if.err),        64'd0);
            chk("quiet_fd",    64'(u_if.frame_done), 64'd0);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_d",     64'(u_if.d),          64'({8{7'b100_0000}}));
        chk("rst_valid", 64'(u_if.valid),      64'd0);
        chk("rst_err",   64'(u_if.err),        64'd0);
        chk("rst_fd",    64'(u_if.frame_done), 64'd0);
    endtask

    initial begin
        logic [7:0] an;
        logic [6:0] sg;
        logic       dp;
        int         sel;

        rst_n       = 1'b0;
        u_if.an_n   = 8'hFF;
        u_if.segs_n = 7'h7F;
        u_if.dp_n   = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        run_quiet(4);

        // Digit 0 shows '1' with decimal point: lands exactly LAT edges after the change.
        apply(8'hFE, ~7'h06, 1'b0);
        run(10);

        // Dash on digit 3, blank on digit 5.
        apply(8'hF7, ~7'h40, 1'b1);
        run(LAT + 2);
        apply(8'hDF, 7'h7F, 1'b1);
        run(LAT + 2);

        // Undecodable pattern, lit-dp-only pattern, and two anodes low.
        apply(8'hFB, ~7'h12, 1'b1);
        run(LAT + 2);
        apply(8'hFB, 7'h7F, 1'b0);
        run(LAT + 2);
        apply(8'hFC, ~7'h3F, 1'b1);
        run(LAT + 2);
        apply(8'hFF, ~7'h3F, 1'b1);
        run(LAT + 2);

        // Two full frames of hex 0..7 across digits 0..7.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                an = 8'hFF;
                an[i] = 1'b0;
                apply(an, ~font[i], 1'b1);
                run(LAT + 3);
            end
        end

        // Glitch every third cycle never lets a pattern settle.
        for (int g = 0; g < 8; g++) begin
            apply(8'hFD, ~7'h5B, 1'b1);
            run_quiet(2);
            apply(8'hFD, ~7'h4F, 1'b1);
            run_quiet(1);
        end
        apply(8'hFD, ~7'h5B, 1'b1);
        run(LAT + 2);

        // Reset asserted two cycles into a dwell, then the held pattern settles afresh.
        apply(8'hF7, ~7'h6D, 1'b0);
        run_quiet(2);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        model_reset();
        run(LAT + 3);

        // Random dwells.
        for (int r = 0; r < 60; r++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                an = 8'hFF;
            end else if (sel == 1) begin
                an = 8'(~((8'd1 << $urandom_range(0, 7)) | (8'd1 << $urandom_range(0, 7))));
            end else begin
                an = 8'(~(8'd1 << $urandom_range(0, 7)));
            end
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                sg = ~font[$urandom_range(0, 15)];
            end else if (sel == 6) begin
                sg = ~7'h40;
            end else if (sel == 7) begin
                sg = 7'h7F;
            end else begin
                sg = 7'($urandom);
            end
            dp = 1'($urandom);
            apply(an, sg, dp);
            run(int'($urandom_range(LAT, LAT + 6)));
        end

        chk("fd_err_exclusive", 64'(n_both), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
